// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;
   localparam int ADDR_W_DEF  = 15;
   localparam int INSTR_W_DEF = 16;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0]  addr;
      logic [INSTR_W_DEF-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; flush wins over push and pop.
module fetch_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n && !flush && do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem read, PC advance, fetch buffer.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [ADDR_W-1:0]  pc_q,
   output logic [ADDR_W-1:0]  pc_d,
   output logic               pc_we,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_addr,
   output logic               dec_valid,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [ADDR_W-1:0]  dec_pc,
   input  logic               dec_ready
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t              state;
   logic [ADDR_W-1:0]         pend_addr;
   logic                      accept;
   logic                      push;
   logic                      pop;
   logic                      empty;
   logic                      full;
   logic [CW-1:0]             count;
   logic [ADDR_W+INSTR_W-1:0] head;
   logic [ADDR_W-1:0]         head_pc;
   logic [INSTR_W-1:0]        head_instr;

   // A redirect withdraws the request so no stale address is ever accepted.
   assign imem_req_valid = reset_n && (state == REQ) &&
                           (count < CW'(DEPTH)) && !redirect_valid;
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid & imem_req_ready;

   assign pc_we = reset_n & (redirect_valid | accept);
   assign pc_d  = !reset_n       ? '0 :
                  redirect_valid ? redirect_addr :
                                   pc_q + ADDR_W'(1);

   assign push = (state == WAIT) && imem_rsp_valid &&
                 !redirect_valid && (!full || pop);
   assign pop  = dec_valid & dec_ready;

   fetch_fifo #(
      .WIDTH(ADDR_W + INSTR_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .flush  (redirect_valid),
      .push   (push),
      .din    ({pend_addr, imem_rsp_data}),
      .pop    (pop),
      .dout   (head),
      .count  (count),
      .empty  (empty),
      .full   (full)
   );

   assign {head_pc, head_instr} = head;
   assign dec_valid = reset_n & !empty;
   assign dec_pc    = reset_n ? head_pc    : '0;
   assign dec_instr = reset_n ? head_instr : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= REQ;
         pend_addr <= '0;
      end else begin
         if (accept) pend_addr <= pc_q;
         unique case (state)
            REQ:   if (accept) state <= WAIT;
            WAIT: begin
               if (imem_rsp_valid)      state <= REQ;
               else if (redirect_valid) state <= FLUSH;
            end
            FLUSH: if (imem_rsp_valid) state <= REQ;
            default: state <= REQ;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: PC register and imem models around instr_fetch_unit.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [14:0] pc_q;
   logic [14:0] pc_d;
   logic        pc_we;
   logic        imem_req_valid;
   logic [14:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [15:0] imem_rsp_data;
   logic        redirect_valid;
   logic [14:0] redirect_addr;
   logic        dec_valid;
   logic [15:0] dec_instr;
   logic [14:0] dec_pc;
   logic        dec_ready;

   instr_fetch_unit #(
      .ADDR_W(15),
      .INSTR_W(16),
      .DEPTH(4)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_q          (pc_q),
      .pc_d          (pc_d),
      .pc_we         (pc_we),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr (imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect_valid(redirect_valid),
      .redirect_addr (redirect_addr),
      .dec_valid     (dec_valid),
      .dec_instr     (dec_instr),
      .dec_pc        (dec_pc),
      .dec_ready     (dec_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_chk = 0;
   int           n_pass = 0;
   int           cyc = 0;
   fetch_entry_t sbq[$];

   logic         last_acc;
   logic [14:0]  last_addr;
   logic [14:0]  last_pcd;
   logic         popped;
   logic [14:0]  last_pop_pc;
   logic         obs_valid;
   logic [14:0]  obs_addr;
   logic         obs_dv;
   int           lat_arm = 0;
   int           t_acc = 0;
   int           mem_delay = 1;
   logic         mb = 1'b0;
   int           mc = 0;
   logic [14:0]  ma = '0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // One clock: observe at negedge, update env state just after posedge.
   task automatic step();
      logic        acc;
      logic [14:0] npc;
      logic [14:0] nx;
      fetch_entry_t e;
      @(negedge clk);
      acc = reset_n && imem_req_valid && imem_req_ready;
      nx  = pc_q + 15'd1;
      obs_valid = imem_req_valid;
      obs_addr  = imem_req_addr;
      obs_dv    = dec_valid;
      if (!reset_n) begin
         chk("rst_ctl", {29'b0, imem_req_valid, pc_we, dec_valid}, 0);
         chk("rst_pcd", {17'b0, pc_d}, 0);
         chk("rst_dec", {1'b0, dec_pc, dec_instr}, 0);
      end else if (redirect_valid) begin
         chk("rdr_noreq", {31'b0, imem_req_valid}, 0);
         chk("rdr_we", {31'b0, pc_we}, 1);
         chk("rdr_pcd", {17'b0, pc_d}, {17'b0, redirect_addr});
      end else if (acc) begin
         chk("acc_addr", {17'b0, imem_req_addr}, {17'b0, pc_q});
         chk("acc_we", {31'b0, pc_we}, 1);
         chk("acc_pcd", {17'b0, pc_d}, {17'b0, nx});
      end else begin
         chk("idle_we", {31'b0, pc_we}, 0);
      end
      popped = reset_n && dec_valid && dec_ready && !redirect_valid;
      if (popped) begin
         last_pop_pc = dec_pc;
         if (sbq.size() == 0) begin
            chk("sb_empty", {1'b0, dec_pc, dec_instr}, 32'hFFFF_FFFF);
         end else begin
            e = sbq.pop_front();
            chk("dec_pc", {17'b0, dec_pc}, {17'b0, e.addr});
            chk("dec_instr", {16'b0, dec_instr}, {16'b0, e.instr});
         end
      end
      if (!reset_n || redirect_valid) sbq.delete();
      if (acc && !redirect_valid) begin
         e.addr  = imem_req_addr;
         e.instr = 16'hA000 | {1'b0, imem_req_addr};
         sbq.push_back(e);
      end
      last_acc = acc;
      if (acc) begin
         last_addr = imem_req_addr;
         last_pcd  = pc_d;
         mb = 1'b1;
         mc = mem_delay;
         ma = imem_req_addr;
      end
      if (lat_arm == 1 && acc) begin
         t_acc = cyc;
         lat_arm = 2;
      end else if (lat_arm == 2 && dec_valid) begin
         chk("latency", cyc - t_acc, 2);
         lat_arm = 0;
      end
      npc = !reset_n ? 15'd0 : (pc_we ? pc_d : pc_q);
      @(posedge clk);
      #1;
      cyc++;
      pc_q = npc;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mb) begin
         mc--;
         if (mc == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 16'hA000 | {1'b0, ma};
            mb = 1'b0;
         end
      end
   endtask

   task automatic wait_acc(input string tag);
      for (int i = 0; i < 30; i++) begin
         step();
         if (last_acc) return;
      end
      chk({"to_acc_", tag}, 0, 1);
   endtask

   task automatic wait_pop(input string tag);
      for (int i = 0; i < 30; i++) begin
         step();
         if (popped) return;
      end
      chk({"to_pop_", tag}, 0, 1);
   endtask

   task automatic redir(input logic [14:0] a);
      redirect_addr  = a;
      redirect_valid = 1'b1;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      logic [14:0] exp_a;
      logic [14:0] a0;
      int          np;
      int          k;
      reset_n        = 1'b0;
      pc_q           = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      dec_ready      = 1'b1;
      repeat (3) step();
      reset_n = 1'b1;
      lat_arm = 1;

      np = 0;
      for (int i = 0; i < 60 && np < 6; i++) begin
         step();
         if (popped) np++;
      end
      chk("t1_pops", np, 6);

      dec_ready = 1'b0;
      repeat (12) step();
      chk("full_noreq", {31'b0, obs_valid}, 0);
      chk("full_cnt", sbq.size(), 4);
      exp_a = sbq[$].addr + 15'd1;
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      step();
      chk("full_resume", {31'b0, last_acc}, 1);
      chk("full_addr", {17'b0, last_addr}, {17'b0, exp_a});
      dec_ready = 1'b1;
      repeat (8) step();

      imem_req_ready = 1'b0;
      repeat (2) step();
      a0 = pc_q;
      repeat (3) begin
         step();
         chk("stall_vld", {31'b0, obs_valid}, 1);
         chk("stall_addr", {17'b0, obs_addr}, {17'b0, a0});
      end
      imem_req_ready = 1'b1;
      step();
      chk("stall_acc", {31'b0, last_acc}, 1);
      chk("stall_pcd", {17'b0, last_pcd}, {17'b0, a0 + 15'd1});
      step();
      chk("stall_single", {31'b0, last_acc}, 0);

      mem_delay = 2;
      wait_acc("t4");
      redir(15'h0100);
      step();
      mem_delay = 1;
      wait_acc("t4b");
      chk("rdr_addr", {17'b0, last_addr}, 32'h100);
      wait_pop("t4");
      chk("rdr_decpc", {17'b0, last_pop_pc}, 32'h100);

      wait_acc("t5");
      redir(15'h0200);
      wait_acc("t5b");
      chk("rsp_rdr_addr", {17'b0, last_addr}, 32'h200);
      wait_pop("t5");
      chk("rsp_rdr_pc", {17'b0, last_pop_pc}, 32'h200);

      wait_acc("t6");
      step();
      redir(15'h0300);
      wait_acc("t6b");
      chk("req_rdr_addr", {17'b0, last_addr}, 32'h300);
      wait_pop("t6");
      chk("req_rdr_pc", {17'b0, last_pop_pc}, 32'h300);

      redir(15'h7FFF);
      wait_acc("wrap");
      chk("wrap_addr", {17'b0, last_addr}, 32'h7FFF);
      chk("wrap_pcd", {17'b0, last_pcd}, 0);
      wait_acc("wrap2");
      chk("wrap_next", {17'b0, last_addr}, 0);

      dec_ready = 1'b0;
      mem_delay = 2;
      k = 0;
      while (k < 40 && !(sbq.size() == 4 && last_acc)) begin
         step();
         k++;
      end
      chk("rst_fill", sbq.size(), 4);
      imem_req_ready = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      chk("rst_empty", {31'b0, obs_dv}, 0);
      step();
      chk("late_rsp", {31'b0, obs_dv}, 0);
      imem_req_ready = 1'b1;
      dec_ready = 1'b1;
      mem_delay = 1;
      wait_pop("rst");
      chk("rst_pc0", {17'b0, last_pop_pc}, 0);

      imem_req_ready = 1'b0;
      repeat (6) step();
      chk("drain", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Consumes the program counter held by the PC register and turns it into a stream of instructions for the decoder. Each cycle it issues instruction-memory reads at the current PC and advances the PC through the register's write port. Fetched words are buffered in a small FIFO together with their addresses. A branch/jump redirect flushes the buffer and any in-flight read.

## Interface
- ADDR_W, 15, PC / instruction-memory word-address width
- INSTR_W, 16, instruction width
- DEPTH, 4, fetch FIFO entries (power of two, ≥2)

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low; clock clk
- pc_q  in  ADDR_W  current PC from the PC register
- pc_d  out  ADDR_W  next PC value to the PC register
- pc_we  out  1  PC register write enable
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  ADDR_W  read address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data valid
- imem_rsp_data  in  INSTR_W  read data
- redirect_valid  in  1  branch/jump taken
- redirect_addr  in  ADDR_W  redirect target
- dec_valid  out  1  instruction available to decoder
- dec_instr  out  INSTR_W  instruction
- dec_pc  out  ADDR_W  address of dec_instr
- dec_ready  in  1  decoder consumes head entry

## Operation
- FSM states:
  - REQ: no read outstanding.
  - WAIT: one read outstanding, response kept.
  - FLUSH: one read outstanding, response to be dropped.
- At most one outstanding read. pend_addr latches the accepted request address.
- REQ:
  - imem_req_valid = (count < DEPTH) & !redirect_valid; imem_req_addr = pc_q.
  - On accept (valid & ready): pc_we=1, pc_d = pc_q+1 mod 2^ADDR_W, pend_addr<=pc_q, go to WAIT.
- WAIT: on imem_rsp_valid, push {pend_addr, imem_rsp_data}, go to REQ.
- FLUSH: on imem_rsp_valid, drop the data, go to REQ.
- Redirect (any state):
  - pc_we=1, pc_d=redirect_addr; this takes priority over the increment.
  - FIFO is cleared at the edge; a same-cycle pop is ignored.
  - Next state:
    - REQ with a same-cycle accept (only possible if valid was 1): FLUSH.
    - WAIT without rsp_valid: FLUSH.
    - WAIT with rsp_valid: the response is dropped, REQ.
    - FLUSH with rsp_valid: REQ.
    - FLUSH otherwise: stay in FLUSH.
- imem_rsp_valid in REQ is a protocol violation and is ignored.
- Request stability: imem_req_addr is held while valid & !ready. A redirect withdraws the request (valid forced 0 that cycle).
- Decoder side:
  - dec_valid = FIFO not empty; dec_instr/dec_pc = head entry.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full (the pop frees the slot).
- pc_we=0 in every cycle without an accept or a redirect.

## Timing
- Reset (reset_n=0 at an edge):
  - State becomes REQ, FIFO empty, pend_addr=0.
  - Outputs while reset_n=0: imem_req_valid=0, pc_we=0, pc_d=0, dec_valid=0, dec_instr=0, dec_pc=0.
- Reset mid-operation: the outstanding read is forgotten; a late response in REQ is ignored.
- Latency:
  - Request accepted at cycle t → pc_q updates at t+1.
  - Earliest response at t+1 → dec_valid at t+2. The FIFO output is registered; there is no bypass.
- Throughput: one instruction per 2 cycles with a 1-cycle memory. This is acceptable for the current design.
- Full: count==DEPTH → no request issued. A request issued at count==DEPTH−1 always fits, because only one read is outstanding.
- Wrap: pc_q = 2^ADDR_W−1 → pc_d = 0.

## Structure
- Package fetch_pkg:
  - State enum {REQ, WAIT, FLUSH}.
  - Default ADDR_W/INSTR_W constants.
  - Fetch entry struct {addr, instr}.
- Sub-module fetch_fifo:
  - Synchronous FIFO with flush, parameterised width/depth.
  - Outputs count, empty, full.
  - Flush has priority over push/pop.
- Top module holds the FSM, pend_addr, PC next-value mux and request logic.

## Test plan
- Reset release, pc_q=0, ready=1, 1-cycle memory returning 0xA000|addr → requests at 0,1,2…; pc_d=1,2,3 with pc_we pulses; decoder sees (0,0xA000),(1,0xA001)… in order.
- dec_ready=0 → after 4 pushes count=4 and imem_req_valid stays 0. One pop → a request issues within 1 cycle and the next address is 4.
- imem_req_ready=0 for 3 cycles → imem_req_valid=1, addr stable, pc_we=0. Ready=1 → a single accept and pc_d=addr+1.
- Redirect to 0x0100 in WAIT, response next cycle:
  - FIFO cleared, response dropped.
  - Next request address is 0x0100; the first dec_pc is 0x0100.
- Redirect coincident with response (WAIT), and coincident with an accept (REQ) → in both cases no stale instruction ever reaches the decoder; pc_d=redirect_addr.
- pc_q=0x7FFF accepted → pc_d=0x0000. Then reset_n=0 with 3 entries queued → dec_valid=0 and imem_req_valid=0 next cycle.
